// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: picks the pattern code shown each frame and
// computes the horizontal ramp increment with a serial divider.
//
// Ports:
//   clk_in, reset        clock, synchronous active-high reset
//   vn_in                vertical sync level; rising edge starts a frame
//   total_active_pix     active pixels per line (ramp divisor)
//   auto_en              1 = cycle patterns every HOLD_FRAMES frames
//   manual_pattern/load  request a specific pattern at the next frame
//   next_req             request a one-step advance at the next frame
//   pattern              current pattern code
//   ramp_step            floor(2^(B+FRACTIONAL_BITS) / total_active_pix)
//   busy                 divider running
//   frame_tick           one-cycle pulse on each vn_in rising edge
module pattern_sequencer #(
   parameter int B               = 8,
   parameter int X_BITS          = 13,
   parameter int FRACTIONAL_BITS = 12,
   parameter int NUM_PATTERNS    = 6,
   parameter int HOLD_FRAMES     = 60
) (
   input  logic                         clk_in,
   input  logic                         reset,
   input  logic                         vn_in,
   input  logic [X_BITS-1:0]            total_active_pix,
   input  logic                         auto_en,
   input  logic [7:0]                   manual_pattern,
   input  logic                         manual_load,
   input  logic                         next_req,
   output logic [7:0]                   pattern,
   output logic [B+FRACTIONAL_BITS-1:0] ramp_step,
   output logic                         busy,
   output logic                         frame_tick
);

   localparam int W = B + FRACTIONAL_BITS;
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(W);
   localparam logic [7:0] LAST_PAT = 8'(NUM_PATTERNS - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
   localparam logic [W:0] NUM_INIT = {1'b1, {W{1'b0}}};

   // ---------------- pattern selection ----------------
   logic        vn_q;
   logic [15:0] hold_cnt;
   logic        man_pend;
   logic [7:0]  man_val;
   logic        adv_pend;
   logic        legal;
   logic        auto_adv;
   logic [7:0]  next_pat;

   // vn_q resets high so a sync already high at release is not a new frame
   assign frame_tick = vn_in & ~vn_q & ~reset;
   assign legal = manual_pattern < 8'(NUM_PATTERNS);
   assign auto_adv = auto_en && (hold_cnt == HOLD_LAST);
   assign next_pat = (pattern == LAST_PAT) ? 8'd0 : pattern + 8'd1;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         vn_q     <= 1'b1;
         pattern  <= '0;
         hold_cnt <= '0;
         man_pend <= 1'b0;
         man_val  <= '0;
         adv_pend <= 1'b0;
      end else begin
         vn_q <= vn_in;
         if (frame_tick) begin
            if (man_pend)
               pattern <= man_val;
            else if (adv_pend || auto_adv)
               pattern <= next_pat;
            if (man_pend || adv_pend || auto_adv)
               hold_cnt <= '0;
            else if (auto_en)
               hold_cnt <= hold_cnt + 16'd1;
            // requests arriving on the tick itself wait for the next frame
            man_pend <= manual_load && legal;
            adv_pend <= next_req;
         end else begin
            if (manual_load && legal)
               man_pend <= 1'b1;
            if (next_req)
               adv_pend <= 1'b1;
         end
         if (manual_load && legal)
            man_val <= manual_pattern;
      end
   end

   // ---------------- ramp divider ----------------
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t            state, state_nx;
   logic              start_pend;
   logic [X_BITS-1:0] dvs;
   logic [X_BITS-1:0] rem;
   logic [W:0]        num;
   logic [W:0]        quo;
   logic [CW-1:0]     cnt;
   logic [X_BITS:0]   trial;
   logic              ge;

   assign trial = {rem, num[W]};
   assign ge = trial >= {1'b0, dvs};
   assign busy = (state != IDLE);

   always_ff @(posedge clk_in) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (start_pend || (total_active_pix != dvs))
               state_nx = (total_active_pix == '0) ? DONE : DIV;
         DIV:
            if (cnt == CNT_LAST)
               state_nx = DONE;
         DONE:
            state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         start_pend <= 1'b1;
         dvs        <= '0;
         rem        <= '0;
         num        <= '0;
         quo        <= '0;
         cnt        <= '0;
         ramp_step  <= '0;
      end else begin
         case (state)
            IDLE:
               if (state_nx != IDLE) begin
                  start_pend <= 1'b0;
                  dvs        <= total_active_pix;
                  rem        <= '0;
                  num        <= NUM_INIT;
                  quo        <= '0;
                  cnt        <= '0;
               end
            DIV: begin
               rem <= ge ? X_BITS'(trial - {1'b0, dvs}) : X_BITS'(trial);
               num <= num << 1;
               quo <= {quo[W-1:0], ge};
               cnt <= cnt + CW'(1);
            end
            DONE:
               // divisor 0 or 1 overflows the output width
               ramp_step <= (dvs == '0 || quo[W]) ? '1 : quo[W-1:0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: divider timing/results,
// pattern priority, auto cycling, wrap and reset behaviour.
module tb_pattern_sequencer;

   localparam int W = 20;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          vn_in;
   logic [12:0]   total_active_pix;
   logic          auto_en;
   logic [7:0]    manual_pattern;
   logic          manual_load;
   logic          next_req;
   logic [7:0]    pattern;
   logic [W-1:0]  ramp_step;
   logic          busy;
   logic          frame_tick;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] ramp_q[$];
   int           len_q[$];
   logic [7:0]   pat_q[$];

   pattern_sequencer #(
      .B(8), .X_BITS(13), .FRACTIONAL_BITS(12),
      .NUM_PATTERNS(6), .HOLD_FRAMES(2)
   ) dut (
      .clk_in(clk_in),
      .reset(reset),
      .vn_in(vn_in),
      .total_active_pix(total_active_pix),
      .auto_en(auto_en),
      .manual_pattern(manual_pattern),
      .manual_load(manual_load),
      .next_req(next_req),
      .pattern(pattern),
      .ramp_step(ramp_step),
      .busy(busy),
      .frame_tick(frame_tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_total(input logic [12:0] v,
                            input logic [W-1:0] exp_ramp,
                            input int exp_len);
      total_active_pix = v;
      ramp_q.push_back(exp_ramp);
      len_q.push_back(exp_len);
   endtask

   task automatic run_div(input string nm);
      int n = 0;
      int len = 0;
      bit hold_ok = 1;
      logic [W-1:0] prev;
      logic [W-1:0] er;
      int el;
      prev = ramp_step;
      er = ramp_q.pop_front();
      el = len_q.pop_front();
      while (!busy && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_start busy=%b required 1", nm, busy);
         return;
      end
      while (busy === 1'b1 && len < 100) begin
         if (ramp_step !== prev) hold_ok = 0;
         len++;
         @(negedge clk_in);
      end
      checks++;
      if (len !== el) begin
         errors++;
         $display("FAIL %s_busy_len got=%0d required=%0d", nm, len, el);
      end
      checks++;
      if (ramp_step !== er) begin
         errors++;
         $display("FAIL %s_ramp got=%h required=%h", nm, ramp_step, er);
      end
      checks++;
      if (!hold_ok) begin
         errors++;
         $display("FAIL %s_hold ramp changed while busy, required %h",
                  nm, prev);
      end
   endtask

   task automatic req(input bit ld, input logic [7:0] code, input bit nx);
      tick();
      manual_load = ld;
      manual_pattern = code;
      next_req = nx;
      tick();
      manual_load = 1'b0;
      next_req = 1'b0;
   endtask

   // exp is the pattern seen during the tick cycle (before it updates)
   task automatic vsync(input bit ld, input logic [7:0] code,
                        input logic [7:0] exp, input string nm);
      logic [7:0] e;
      pat_q.push_back(exp);
      tick();
      vn_in = 1'b1;
      manual_load = ld;
      manual_pattern = code;
      @(negedge clk_in);
      e = pat_q.pop_front();
      checks++;
      if (frame_tick !== 1'b1) begin
         errors++;
         $display("FAIL %s_tick frame_tick=%b required 1", nm, frame_tick);
      end
      checks++;
      if (pattern !== e) begin
         errors++;
         $display("FAIL %s_pattern got=%0d required=%0d", nm, pattern, e);
      end
      tick();
      manual_load = 1'b0;
      @(negedge clk_in);
      checks++;
      if (frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL %s_pulse frame_tick=%b required 0", nm, frame_tick);
      end
      tick();
      vn_in = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vn_in = 1'b1;
      total_active_pix = 13'd1280;
      auto_en = 1'b0;
      manual_pattern = 8'd0;
      manual_load = 1'b0;
      next_req = 1'b0;
      repeat (3) tick();
      @(negedge clk_in);
      checks++;
      if (pattern !== 8'd0) begin
         errors++;
         $display("FAIL rst_pattern got=%0d required=0", pattern);
      end
      checks++;
      if (ramp_step !== '0) begin
         errors++;
         $display("FAIL rst_ramp got=%h required=0", ramp_step);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy got=%b required=0", busy);
      end
      checks++;
      if (frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL rst_tick got=%b required=0", frame_tick);
      end
   endtask

   task automatic test_ramp_1280();
      tick();
      ramp_q.push_back(20'h00333);
      len_q.push_back(22);
      reset = 1'b0;
      @(negedge clk_in);
      checks++;
      if (frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL release_tick got=%b required=0", frame_tick);
      end
      run_div("div1280");
      vn_in = 1'b0;
   endtask

   task automatic test_ramp_edges();
      set_total(13'd1, 20'hFFFFF, 22);
      run_div("div1");
      set_total(13'd0, 20'hFFFFF, 1);
      run_div("div0");
      set_total(13'd1920, 20'd546, 22);
      run_div("div1920");
      set_total(13'd1280, 20'd819, 22);
      run_div("div1280b");
   endtask

   task automatic test_auto();
      auto_en = 1'b1;
      vsync(0, 8'd0, 8'd0, "auto1");
      vsync(0, 8'd0, 8'd0, "auto2");
      vsync(0, 8'd0, 8'd1, "auto3");
      vsync(0, 8'd0, 8'd1, "auto4");
      vsync(0, 8'd0, 8'd2, "auto5");
      vsync(0, 8'd0, 8'd2, "auto6");
      vsync(0, 8'd0, 8'd3, "auto7");
      auto_en = 1'b0;
   endtask

   task automatic test_manual();
      req(1, 8'd5, 1);
      vsync(0, 8'd0, 8'd3, "man_apply");
      vsync(0, 8'd0, 8'd5, "man_loaded");
      req(1, 8'd9, 0);
      vsync(0, 8'd0, 8'd5, "illegal1");
      vsync(0, 8'd0, 8'd5, "illegal2");
   endtask

   task automatic test_wrap();
      req(0, 8'd0, 1);
      vsync(0, 8'd0, 8'd5, "wrap_apply");
      vsync(0, 8'd0, 8'd0, "wrap_zero");
   endtask

   task automatic test_back_to_back();
      vsync(1, 8'd2, 8'd0, "same_cyc1");
      vsync(0, 8'd0, 8'd0, "same_cyc2");
      vsync(0, 8'd0, 8'd2, "same_cyc3");
      req(0, 8'd0, 1);
      req(0, 8'd0, 1);
      vsync(0, 8'd0, 8'd2, "multi_next1");
      vsync(0, 8'd0, 8'd3, "multi_next2");
      req(1, 8'd4, 0);
      req(1, 8'd9, 0);
      vsync(0, 8'd0, 8'd3, "keep_pend1");
      vsync(0, 8'd0, 8'd4, "keep_pend2");
   endtask

   task automatic test_reset_mid_div();
      total_active_pix = 13'd1000;
      repeat (6) @(negedge clk_in);
      checks++;
      if (busy !== 1'b1 || ramp_step !== 20'd819) begin
         errors++;
         $display("FAIL mid_div busy=%b ramp=%h required busy=1 ramp=00333",
                  busy, ramp_step);
      end
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk_in);
      checks++;
      if (ramp_step !== '0 || busy !== 1'b0 || pattern !== 8'd0) begin
         errors++;
         $display("FAIL abort ramp=%h busy=%b pat=%0d required 0 0 0",
                  ramp_step, busy, pattern);
      end
      tick();
      set_total(13'd1280, 20'h00333, 22);
      reset = 1'b0;
      run_div("restart");
   endtask

   initial begin
      test_reset();
      test_ramp_1280();
      test_ramp_edges();
      test_auto();
      test_manual();
      test_wrap();
      test_back_to_back();
      test_reset_mid_div();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter B, default 8, bits per colour channel.
REQ-002 SHALL have parameter X_BITS, default 13, width of pixel-count input.
REQ-003 SHALL have parameter FRACTIONAL_BITS, default 12, fractional bits of ramp_step.
REQ-004 SHALL have parameter NUM_PATTERNS, default 6, number of legal pattern codes (0..NUM_PATTERNS-1).
REQ-005 SHALL have parameter HOLD_FRAMES, default 60, frames each pattern is held in auto mode; legal range 1..65535.
REQ-006 SHALL have port clk_in  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port vn_in  input  1  vertical sync, active-high level.
REQ-009 SHALL have port total_active_pix  input  X_BITS  active pixels per line.
REQ-010 SHALL have port auto_en  input  1  1 = auto-cycle patterns, 0 = hold.
REQ-011 SHALL have port manual_pattern  input  8  pattern code for manual load.
REQ-012 SHALL have port manual_load  input  1  single-cycle request to load manual_pattern.
REQ-013 SHALL have port next_req  input  1  single-cycle request to advance one pattern.
REQ-014 SHALL have port pattern  output  8  registered pattern code for the generator.
REQ-015 SHALL have port ramp_step  output  B+FRACTIONAL_BITS  registered ramp increment.
REQ-016 SHALL have port busy  output  1  high while divider runs.
REQ-017 SHALL have port frame_tick  output  1  one-cycle pulse per vn_in rising edge.

Function
REQ-018 SHALL register vn_in once; frame_tick = vn_in & ~vn_in_q, one cycle, same cycle pattern may change.
REQ-019 SHALL change pattern only on a frame_tick cycle (takes effect on the following clock edge); never mid-frame.
REQ-020 SHALL accept manual_load only when manual_pattern < NUM_PATTERNS, storing it as pending; illegal codes ignored, prior pending kept.
REQ-021 SHALL store next_req as a pending-advance flag; multiple requests within one frame = one advance.
REQ-022 SHALL, on frame_tick, apply priority: pending manual load > pending advance > auto advance; clear both pending flags; clear hold counter if any change applied.
REQ-023 SHALL, in auto mode, count frame_ticks in a 16-bit hold counter; on the tick where counter == HOLD_FRAMES-1, advance and clear counter; counter frozen at current value while auto_en = 0.
REQ-024 SHALL advance as pattern+1, wrapping NUM_PATTERNS-1 -> 0.
REQ-025 SHALL, when manual_load/next_req arrive in the same cycle as frame_tick, treat them as pending for the next frame_tick.
REQ-026 SHALL compute ramp_step = floor(2^(B+FRACTIONAL_BITS) / total_active_pix) with a serial restoring divider, one quotient bit per cycle.
REQ-027 Divider FSM states: IDLE, DIV, DONE; IDLE->DIV when total_active_pix != latched copy or on first cycle after reset; latch divisor on entry.
REQ-028 DIV SHALL last exactly B+FRACTIONAL_BITS+1 cycles; DIV->DONE; DONE writes ramp_step in one cycle and returns to IDLE.
REQ-029 busy SHALL be high in DIV and DONE, low in IDLE.
REQ-030 SHALL saturate ramp_step to all ones when quotient >= 2^(B+FRACTIONAL_BITS) (divisor 1) and, when divisor 0, skip DIV, go IDLE->DONE, write all ones.
REQ-031 SHALL ignore total_active_pix changes during DIV; a mismatch seen after return to IDLE restarts division.
REQ-032 ramp_step SHALL hold its previous value until DONE; no partial quotient visible.

Reset
REQ-033 SHALL, while reset high: pattern = 0, ramp_step = 0, busy = 0, frame_tick = 0, hold counter = 0, pending flags cleared, FSM = IDLE, vn_in_q = 1 (no spurious tick if vn_in high at release).
REQ-034 SHALL abort any division in progress when reset asserts; division restarts on first cycle after release.

Verification
REQ-035 total_active_pix = 1280 after reset -> busy high 22 cycles, then ramp_step = 819 (0x00333).
REQ-036 total_active_pix = 1 -> ramp_step = 0xFFFFF; total_active_pix = 0 -> ramp_step = 0xFFFFF, busy high 1 cycle.
REQ-037 HOLD_FRAMES = 2, auto_en = 1, 7 vsync pulses -> pattern 0,0,1,1,2,2,3 sampled after each tick.
REQ-038 manual_load with 5 mid-frame plus next_req same frame -> pattern 5 at next tick; next tick unchanged (auto_en = 0); manual_pattern 9 -> ignored.
REQ-039 pattern = 5, next_req -> pattern 0 at next tick (wrap).
REQ-040 reset asserted mid-DIV with ramp_step = 819 -> ramp_step = 0, busy = 0; after release, recompute completes with 819.
